// File: rtl/wkup_bus_arbiter_pkg.sv
// Shared types for the result-wakeup broadcast path (arbiter and issue-queue tag compare).
package wkup_bus_arbiter_pkg;

  localparam int PREG_W = 6;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    word_t             data;
  } wkup_pkt_t;

endpackage

// File: rtl/wkup_bus_arbiter_rr_multi_grant.sv
// Combinational round-robin picker: grants up to WKUP_COUNT candidates scanning from start_ptr.
module wkup_bus_arbiter_rr_multi_grant #(
  parameter int REQ_COUNT  = 4,
  parameter int WKUP_COUNT = 2,
  parameter int IDX_W      = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0]                  cand,
  input  logic [IDX_W-1:0]                      start_ptr,
  output logic [WKUP_COUNT-1:0][REQ_COUNT-1:0]  slot_sel,
  output logic [WKUP_COUNT-1:0]                 slot_valid,
  output logic [IDX_W-1:0]                      last_idx
);

  localparam int SLOT_W = (WKUP_COUNT > 1) ? $clog2(WKUP_COUNT) : 1;
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [IDX_W:0]   REQ_N = REQ_COUNT[IDX_W:0];
  localparam logic [CNT_W-1:0] WK_N  = WKUP_COUNT[CNT_W-1:0];

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // cnt is the number of grants already handed out; the next grant takes slot cnt.
  always_comb begin
    slot_sel   = '0;
    slot_valid = '0;
    last_idx   = start_ptr;
    cnt        = '0;
    sum        = '0;
    idx        = '0;
    for (int j = 0; j < REQ_COUNT; j++) begin
      sum = {1'b0, start_ptr} + (IDX_W + 1)'(j);
      if (sum >= REQ_N) sum = sum - REQ_N;
      idx = sum[IDX_W-1:0];
      if (cand[idx] && (cnt < WK_N)) begin
        slot_sel[cnt[SLOT_W-1:0]][idx] = 1'b1;
        slot_valid[cnt[SLOT_W-1:0]]    = 1'b1;
        last_idx                       = idx;
        cnt                            = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wkup_bus_arbiter.sv
// Shares WKUP_COUNT registered wakeup slots among REQ_COUNT producers; losers park in a one-entry buffer.
module wkup_bus_arbiter #(
  parameter int REQ_COUNT  = 4,
  parameter int WKUP_COUNT = 2,
  parameter int PREG_W     = wkup_bus_arbiter_pkg::PREG_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [REQ_COUNT-1:0]               req_valid_i,
  input  logic [REQ_COUNT-1:0][PREG_W-1:0]   req_preg_i,
  input  logic [REQ_COUNT-1:0][31:0]         req_data_i,
  output logic [REQ_COUNT-1:0]               req_ready_o,
  output logic [WKUP_COUNT-1:0]              wkup_valid_o,
  output logic [WKUP_COUNT-1:0][PREG_W-1:0]  wkup_preg_o,
  output logic [WKUP_COUNT-1:0][31:0]        wkup_data_o
);

  import wkup_bus_arbiter_pkg::word_t;

  // Handshake: a producer result transfers on a cycle where req_valid_i[i] & req_ready_o[i].
  // ready is a pure register (~buf_valid), so a producer never sees a same-cycle valid->ready path.

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_COUNT - 1);

  logic [REQ_COUNT-1:0]               buf_valid;
  logic [REQ_COUNT-1:0][PREG_W-1:0]   buf_preg;
  word_t [REQ_COUNT-1:0]              buf_data;
  logic [IDX_W-1:0]                   rr_ptr;

  logic [REQ_COUNT-1:0]               cand;
  logic [REQ_COUNT-1:0][PREG_W-1:0]   cand_preg;
  word_t [REQ_COUNT-1:0]              cand_data;
  logic [REQ_COUNT-1:0]               granted;

  logic [WKUP_COUNT-1:0][REQ_COUNT-1:0] slot_sel;
  logic [WKUP_COUNT-1:0]                slot_valid;
  logic [WKUP_COUNT-1:0][PREG_W-1:0]    slot_preg;
  word_t [WKUP_COUNT-1:0]               slot_data;
  logic [IDX_W-1:0]                     last_idx;
  logic [IDX_W-1:0]                     next_ptr;
  logic                                 any_grant;

  // A buffered entry always outranks the (back-pressured, hence ignored) incoming one.
  always_comb begin
    cand      = buf_valid | req_valid_i;
    cand_preg = '0;
    cand_data = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      cand_preg[i] = buf_valid[i] ? buf_preg[i] : req_preg_i[i];
      cand_data[i] = buf_valid[i] ? buf_data[i] : req_data_i[i];
    end
  end

  wkup_bus_arbiter_rr_multi_grant #(
    .REQ_COUNT  (REQ_COUNT),
    .WKUP_COUNT (WKUP_COUNT),
    .IDX_W      (IDX_W)
  ) u_rr_multi_grant (
    .cand       (cand),
    .start_ptr  (rr_ptr),
    .slot_sel   (slot_sel),
    .slot_valid (slot_valid),
    .last_idx   (last_idx)
  );

  always_comb begin
    granted   = '0;
    slot_preg = '0;
    slot_data = '0;
    for (int k = 0; k < WKUP_COUNT; k++) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (slot_sel[k][i]) begin
          granted[i]   = 1'b1;
          slot_preg[k] = slot_preg[k] | cand_preg[i];
          slot_data[k] = slot_data[k] | cand_data[i];
        end
      end
    end
  end

  assign any_grant   = slot_valid[0];
  assign next_ptr    = (last_idx == LAST_IDX) ? '0 : last_idx + IDX_W'(1);
  assign req_ready_o = ~buf_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid    <= '0;
      buf_preg     <= '0;
      buf_data     <= '0;
      rr_ptr       <= '0;
      wkup_valid_o <= '0;
      wkup_preg_o  <= '0;
      wkup_data_o  <= '0;
    end else if (flush) begin
      buf_valid    <= '0;
      wkup_valid_o <= '0;
      wkup_preg_o  <= '0;
      wkup_data_o  <= '0;
    end else begin
      wkup_valid_o <= slot_valid;
      wkup_preg_o  <= slot_preg;
      wkup_data_o  <= slot_data;
      if (any_grant) rr_ptr <= next_ptr;
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (buf_valid[i]) begin
          if (granted[i]) buf_valid[i] <= 1'b0;
        end else if (req_valid_i[i] && !granted[i]) begin
          buf_valid[i] <= 1'b1;
          buf_preg[i]  <= req_preg_i[i];
          buf_data[i]  <= req_data_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wkup_bus_arbiter.sv
// Self-checking bench for wkup_bus_arbiter (REQ_COUNT=4, WKUP_COUNT=2, PREG_W=6).
module tb_wkup_bus_arbiter;

  localparam int RC = 4;
  localparam int WC = 2;
  localparam int PW = 6;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [RC-1:0]        req_valid_i;
  logic [RC-1:0][PW-1:0] req_preg_i;
  logic [RC-1:0][31:0]  req_data_i;
  logic [RC-1:0]        req_ready_o;
  logic [WC-1:0]        wkup_valid_o;
  logic [WC-1:0][PW-1:0] wkup_preg_o;
  logic [WC-1:0][31:0]  wkup_data_o;

  always #5 clk = ~clk;

  wkup_bus_arbiter #(.REQ_COUNT(RC), .WKUP_COUNT(WC), .PREG_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid_i  (req_valid_i),
    .req_preg_i   (req_preg_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .wkup_valid_o (wkup_valid_o),
    .wkup_preg_o  (wkup_preg_o),
    .wkup_data_o  (wkup_data_o)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [WC-1:0]         vld;
    logic [WC-1:0][PW-1:0] preg;
    logic [WC-1:0][31:0]   data;
    logic [RC-1:0]         rdy;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  logic [RC-1:0]         m_bv;
  logic [RC-1:0][PW-1:0] m_bp;
  logic [RC-1:0][31:0]   m_bd;
  int                    m_rr;

  // tag bookkeeping for the saturation run
  logic seen[64];
  int   issue_cyc[64];
  int   prod_of[64];
  int   gcnt[RC];
  logic track_en = 1'b0;
  logic count_en = 1'b0;
  int   next_tag = 0;

  logic [RC-1:0]         v;
  logic [RC-1:0][PW-1:0] p;
  logic [RC-1:0][31:0]   d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_bv = '0;
    m_bp = '0;
    m_bd = '0;
    m_rr = 0;
  endtask

  task automatic model_step(input logic [RC-1:0] mv, input logic [RC-1:0][PW-1:0] mp,
                            input logic [RC-1:0][31:0] md, input logic fl, output exp_t e);
    logic [RC-1:0] cand;
    logic [RC-1:0] gnt;
    int n;
    int last;
    int idx;
    e = '0;
    if (fl) begin
      m_bv = '0;
    end else begin
      cand = m_bv | mv;
      gnt  = '0;
      n    = 0;
      last = 0;
      for (int j = 0; j < RC; j++) begin
        idx = (m_rr + j) % RC;
        if (cand[idx] && n < WC) begin
          e.vld[n]  = 1'b1;
          e.preg[n] = m_bv[idx] ? m_bp[idx] : mp[idx];
          e.data[n] = m_bv[idx] ? m_bd[idx] : md[idx];
          gnt[idx]  = 1'b1;
          last      = idx;
          n++;
        end
      end
      for (int i = 0; i < RC; i++) begin
        if (m_bv[i]) begin
          if (gnt[i]) m_bv[i] = 1'b0;
        end else if (mv[i] && !gnt[i]) begin
          m_bv[i] = 1'b1;
          m_bp[i] = mp[i];
          m_bd[i] = md[i];
        end
      end
      if (n > 0) m_rr = (last + 1) % RC;
    end
    e.rdy = ~m_bv;
  endtask

  // ---------------- driver: one clock of stimulus, then compare ----------------
  task automatic drive(input logic fl);
    exp_t e;
    exp_t g;
    logic [PW-1:0] tg;
    req_valid_i = v;
    req_preg_i  = p;
    req_data_i  = d;
    flush       = fl;
    model_step(v, p, d, fl, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() != 1) begin
      check("sb_depth", 64'(exp_q.size()), 64'd1);
    end else begin
      g = exp_q.pop_front();
      check("wkup_valid", 64'(wkup_valid_o), 64'(g.vld));
      for (int k = 0; k < WC; k++) begin
        check("wkup_preg", 64'(wkup_preg_o[k]), 64'(g.preg[k]));
        check("wkup_data", 64'(wkup_data_o[k]), 64'(g.data[k]));
      end
      check("ready", 64'(req_ready_o), 64'(g.rdy));
    end
    if (track_en) begin
      for (int k = 0; k < WC; k++) begin
        if (wkup_valid_o[k]) begin
          tg = wkup_preg_o[k];
          check("dup_tag", 64'(seen[tg]), 64'd0);
          seen[tg] = 1'b1;
          check("wait_le_2", 64'((cyc - issue_cyc[tg]) <= 2), 64'd1);
          if (count_en) gcnt[prod_of[tg]]++;
        end
      end
    end
    flush       = 1'b0;
    req_valid_i = '0;
  endtask

  task automatic idle_inputs();
    v = '0;
    p = '0;
    d = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    req_valid_i = '0;
    req_preg_i  = '0;
    req_data_i  = '0;
    idle_inputs();
    model_reset();
    for (int t = 0; t < 64; t++) begin
      seen[t] = 1'b0; issue_cyc[t] = 0; prod_of[t] = 0;
    end
    for (int i = 0; i < RC; i++) gcnt[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(wkup_valid_o), 64'd0);
    check("rst_preg",  64'(wkup_preg_o), 64'd0);
    check("rst_data",  64'(wkup_data_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'hF);
    rst = 1'b0;

    // 1: single bypass request, one-cycle latency
    idle_inputs();
    v[2] = 1'b1; p[2] = 6'd5; d[2] = 32'hDEADBEEF;
    drive(1'b0);
    check("t1_valid", 64'(wkup_valid_o), 64'b01);
    check("t1_preg",  64'(wkup_preg_o[0]), 64'd5);
    check("t1_data",  64'(wkup_data_o[0]), 64'hDEADBEEF);
    check("t1_ready", 64'(req_ready_o), 64'hF);
    idle_inputs();
    drive(1'b0);
    check("idle_valid", 64'(wkup_valid_o), 64'd0);

    // 2: all four request with rr_ptr = 0 (producer 2 moved it to 3, so realign with producer 3)
    v = 4'b1000; p[3] = 6'd9;
    drive(1'b0);
    v = 4'b1111; p = {6'd4, 6'd3, 6'd2, 6'd1};
    for (int i = 0; i < RC; i++) d[i] = $urandom;
    drive(1'b0);
    check("t2_preg0", 64'(wkup_preg_o[0]), 64'd1);
    check("t2_preg1", 64'(wkup_preg_o[1]), 64'd2);
    check("t2_ready", 64'(req_ready_o), 64'b0011);
    idle_inputs();
    drive(1'b0);
    check("t2b_preg0", 64'(wkup_preg_o[0]), 64'd3);
    check("t2b_preg1", 64'(wkup_preg_o[1]), 64'd4);
    check("t2b_ready", 64'(req_ready_o), 64'hF);
    // rr_ptr back at 0: producer 0 must take slot 0 ahead of producer 3
    v = 4'b1001; p[0] = 6'd7; p[3] = 6'd8;
    drive(1'b0);
    check("t2_rr0", 64'(wkup_preg_o[0]), 64'd7);

    // 3: wrap-around from rr_ptr = 3
    idle_inputs();
    v[2] = 1'b1; p[2] = 6'd9;
    drive(1'b0);
    v = 4'b1011; p[0] = 6'd10; p[1] = 6'd11; p[3] = 6'd13; d = '0; d[1] = 32'h1111_0001;
    drive(1'b0);
    check("t3_slot0", 64'(wkup_preg_o[0]), 64'd13);
    check("t3_slot1", 64'(wkup_preg_o[1]), 64'd10);
    check("t3_ready", 64'(req_ready_o), 64'b1101);
    v = 4'b0110; p[1] = 6'd50; p[2] = 6'd12;
    drive(1'b0);
    check("t3_rr1_slot0", 64'(wkup_preg_o[0]), 64'd11);
    check("t3_rr1_data0", 64'(wkup_data_o[0]), 64'h1111_0001);
    check("t3_rr1_slot1", 64'(wkup_preg_o[1]), 64'd12);

    // 5: flush while producers 2 and 3 are buffered
    idle_inputs();
    v[3] = 1'b1; p[3] = 6'd20;
    drive(1'b0);
    v = 4'b1111; p = {6'd24, 6'd23, 6'd22, 6'd21};
    drive(1'b0);
    check("t5_ready_pre", 64'(req_ready_o), 64'b0011);
    idle_inputs();
    v[0] = 1'b1; p[0] = 6'h2A; d[0] = 32'hBAD0_002A;
    drive(1'b1);
    check("t5_flush_valid", 64'(wkup_valid_o), 64'd0);
    check("t5_flush_ready", 64'(req_ready_o), 64'hF);
    idle_inputs();
    drive(1'b0);
    check("t5_dropped", 64'(wkup_valid_o), 64'd0);
    // rr_ptr held at 2 across the flush: producer 3 outranks producer 0
    v = 4'b1001; p[0] = 6'd30; p[3] = 6'd33;
    drive(1'b0);
    check("t5_rr_hold", 64'(wkup_preg_o[0]), 64'd33);

    // random traffic with occasional flush
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < RC; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        p[i] = PW'($urandom_range(0, 63));
        d[i] = $urandom;
      end
      drive($urandom_range(0, 15) == 0);
    end

    // 4: sustained saturation from a clean reset
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    track_en = 1'b1;
    count_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < RC; i++) begin
        if (!m_bv[i]) begin
          p[i] = PW'(next_tag);
          d[i] = $urandom;
          issue_cyc[next_tag] = cyc;
          prod_of[next_tag]   = i;
          next_tag++;
        end
      end
      v = '1;
      drive(1'b0);
    end
    count_en = 1'b0;
    idle_inputs();
    repeat (2) drive(1'b0);
    track_en = 1'b0;
    for (int i = 0; i < RC; i++) check($sformatf("t4_grants_p%0d", i), 64'(gcnt[i]), 64'd10);
    for (int t = 0; t < next_tag; t++) check("t4_lost_tag", 64'(seen[t]), 64'd1);

    // 6: asynchronous reset mid-cycle while slots are valid
    v = 4'b1111; p = {6'd44, 6'd43, 6'd42, 6'd41};
    drive(1'b0);
    check("t6_pre_valid", 64'(wkup_valid_o), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(wkup_valid_o), 64'd0);
    check("t6_async_preg",  64'(wkup_preg_o), 64'd0);
    check("t6_async_data",  64'(wkup_data_o), 64'd0);
    check("t6_async_ready", 64'(req_ready_o), 64'hF);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = 4'b1001; p[0] = 6'd1; p[3] = 6'd3;
    drive(1'b0);
    check("t6_rr0", 64'(wkup_preg_o[0]), 64'd1);
    idle_inputs();
    drive(1'b0);
    check("t6_no_stale", 64'(wkup_valid_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wkup_bus_arbiter.md
Name: wkup_bus_arbiter

Overview:
Shares the WKUP_COUNT result-wakeup broadcast slots among REQ_COUNT producing execution units.
- Each producer presents one result per cycle (physical register tag plus data).
- Up to WKUP_COUNT winners are chosen round-robin each cycle and driven onto registered wakeup slots.
- These slots feed the issue queues' tag-hit compare and the one-cycle-later data-forwarding stage.
- Each producer that loses arbitration has its result held in a one-entry buffer, and that producer is back-pressured until the result is broadcast.

Parameters:
REQ_COUNT, 4, number of producing execution units (>= 2)
WKUP_COUNT, 2, number of wakeup broadcast slots (1 <= WKUP_COUNT <= REQ_COUNT)
PREG_W, 6, physical register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  pipeline flush; drops all pending results
req_valid_i  in  REQ_COUNT  producer i offers a result this cycle
req_preg_i  in  REQ_COUNT x PREG_W  destination tag per producer
req_data_i  in  REQ_COUNT x 32 (word_t)  result data per producer
req_ready_o  out  REQ_COUNT  producer i may offer a result (handshake = valid & ready)
wkup_valid_o  out  WKUP_COUNT  slot carries a broadcast this cycle
wkup_preg_o  out  WKUP_COUNT x PREG_W  broadcast tag
wkup_data_o  out  WKUP_COUNT x 32  broadcast data

Behaviour:
Reset (rst = 1, asynchronous):
- hold buffers invalid
- rr_ptr = 0
- wkup_valid_o = 0; wkup_preg_o = 0; wkup_data_o = 0
- req_ready_o = all ones once released

Per-requester state:
- buf_valid[i], buf_preg[i], buf_data[i].
- req_ready_o[i] = ~buf_valid[i]. This is purely registered, with no combinational path from req_valid_i.

Candidate i in a cycle:
- If buf_valid[i]: the buffered entry is the candidate.
- Else if req_valid_i[i]: the incoming entry is the candidate (bypass).
- Else: no candidate.

Grant:
- Scan i = rr_ptr, rr_ptr+1, ... mod REQ_COUNT.
- The first WKUP_COUNT candidates found are granted.
- The k-th grant in scan order takes slot k.

Output registers (clock edge):
- Granted slot k: wkup_valid_o[k] <= 1; tag and data come from the granted candidate.
- Unused slots: valid <= 0, tag <= 0, data <= 0.
- Latency: a bypass result accepted in cycle T appears on the slot in cycle T+1.

Buffer update:
- Incoming accepted but not granted: buffer loads it, and ready drops next cycle.
- Buffered entry granted: buf_valid <= 0, and ready rises next cycle.
- Buffered entry not granted: entry is held unchanged.
- An entry is never lost or duplicated.

rr_ptr update:
- If any grant: rr_ptr <= (index of last granted requester + 1) mod REQ_COUNT.
- No grants: rr_ptr holds.

Starvation bound: a pending entry is granted within ceil(REQ_COUNT/WKUP_COUNT) cycles.

Boundary conditions:
- All requesters active: exactly WKUP_COUNT grants per cycle, rotating fairly.
- No candidates: all wkup_valid_o = 0 next cycle.
- Wrap-around: the scan continues past REQ_COUNT-1 to index 0.
- rr_ptr stays in the range 0..REQ_COUNT-1.

Flush:
- Synchronous, with priority over the grant.
- In the flush cycle: all buf_valid <= 0 and all wkup_valid_o <= 0.
- Incoming requests in that cycle are dropped.
- rr_ptr holds.
- Slot outputs already registered before the flush edge remain visible for their cycle.

Reset mid-operation: asynchronously clears everything; no partial broadcast survives.

Decomposition:
Shared package:
- wkup_pkt_t = {preg: PREG_W bits, data: word_t}
- tag-width constant PREG_W, shared with the issue queues

Sub-module rr_multi_grant (combinational):
- Inputs: candidate mask and start pointer.
- Outputs: per-slot one-hot requester select, per-slot valid, and the last granted index.
- The top level holds the buffers, rr_ptr, and output registers.

Test Plan (REQ_COUNT=4, WKUP_COUNT=2, PREG_W=6):
1. Reset, then a single request at T: producer 2 with preg 5, data 0xDEADBEEF -> slot 0 at T+1 shows valid, preg 5, data 0xDEADBEEF; slot 1 invalid; ready_o stays 4'b1111.
2. All four request at T with rr_ptr=0 and tags 1,2,3,4 -> at T+1 slots carry tags 1 and 2; producers 2 and 3 are buffered and ready_o = 4'b0011; at T+2 slots carry 3 and 4, with rr_ptr = 0 afterwards.
3. Wrap-around: rr_ptr=3, requests at 0, 1 and 3 -> slot 0 = producer 3, slot 1 = producer 0; producer 1 buffered; rr_ptr becomes 1.
4. Sustained saturation, all valid for 20 cycles with no flush -> each producer gets exactly 10 grants; no producer waits more than 2 cycles; no tag is duplicated or lost (scoreboard check).
5. Flush while producers 2 and 3 are buffered -> next cycle all wkup_valid_o = 0 and ready_o = 4'b1111; a request presented in the flush cycle never appears.
6. rst pulse asynchronously mid-cycle while outputs are valid -> wkup_valid_o drops immediately without waiting for a clock edge; buffers are cleared and rr_ptr = 0.
